// File: rtl/mastermind_round_ctrl.sv
// Round sequencer for the Mastermind board: turns load-button presses into code/guess
// load strobes, runs the clear + 4-step compare sweep, scores each guess, tracks win/loss.
`timescale 1ns/1ps
module mastermind_round_ctrl #(
  parameter int MAX_GUESSES = 8,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [2:0]       red_in,
  output logic             load_code_en,
  output logic             load_guess_en,
  output logic [1:0]       pos_sel,
  output logic             cmp_clear,
  output logic             cmp_en,
  output logic [1:0]       cmp_idx,
  output logic             score_valid,
  output logic [CNT_W-1:0] guess_count,
  output logic             game_won,
  output logic             game_lost
);

  typedef enum logic [2:0] {
    S_CODE, S_GUESS, S_CLEAR, S_CMP, S_SCORE, S_WON, S_LOST
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_GUESSES);

  state_t     state;
  logic [1:0] pos;
  logic       load_q;
  logic       press;

  assign press = load & ~load_q;

  // pos doubles as the entry position and as the compare index during the sweep.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_CODE;
      pos         <= '0;
      // NOTE: load_q resets high so a button held across reset release is not seen as a press.
      load_q      <= 1'b1;
      guess_count <= '0;
    end else begin
      // NOTE: every register here uses <= so all updates see the same pre-edge values.
      load_q <= load;
      case (state)
        S_CODE: begin
          if (press) begin
            pos <= pos + 2'd1;
            if (pos == 2'd3) state <= S_GUESS;
          end
        end
        S_GUESS: begin
          if (press) begin
            pos <= pos + 2'd1;
            if (pos == 2'd3) state <= S_CLEAR;
          end
        end
        S_CLEAR: state <= S_CMP;
        S_CMP: begin
          pos <= pos + 2'd1;
          if (pos == 2'd3) state <= S_SCORE;
        end
        S_SCORE: begin
          if (guess_count != MAX_CNT) guess_count <= guess_count + CNT_W'(1);
          pos <= '0;
          // Win beats loss when the final guess is correct.
          if (red_in == 3'd4)                           state <= S_WON;
          else if (guess_count + CNT_W'(1) == MAX_CNT)  state <= S_LOST;
          else                                          state <= S_GUESS;
        end
        S_WON, S_LOST: begin
          if (press) begin
            state       <= S_CODE;
            pos         <= '0;
            guess_count <= '0;
          end
        end
        default: state <= S_CODE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset clears them at once.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves an output unassigned (no latches).
    load_code_en  = 1'b0;
    load_guess_en = 1'b0;
    cmp_clear     = 1'b0;
    cmp_en        = 1'b0;
    cmp_idx       = 2'd0;
    score_valid   = 1'b0;
    game_won      = 1'b0;
    game_lost     = 1'b0;
    pos_sel       = pos;
    case (state)
      S_CODE:  load_code_en  = press;
      S_GUESS: load_guess_en = press;
      S_CLEAR: cmp_clear     = 1'b1;
      S_CMP: begin
        cmp_en  = 1'b1;
        cmp_idx = pos;
      end
      S_SCORE: score_valid   = 1'b1;
      S_WON:   game_won      = 1'b1;
      S_LOST:  game_lost     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// Directed bench for mastermind_round_ctrl: strobe events are scoreboarded through a queue,
// levels (guess_count, won/lost, reset values) are checked inline.
`timescale 1ns/1ps
module tb_mastermind_round_ctrl;

  typedef enum int {K_CODE, K_GUESS, K_CLEAR, K_CMP, K_SCORE} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [1:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       resetn_a, resetn_b, load, use_b;
  logic [2:0] red_in;

  logic       a_code, a_guess, a_clear, a_cmp, a_score, a_won, a_lost;
  logic [1:0] a_pos, a_idx;
  logic [3:0] a_gc;
  logic       b_code, b_guess, b_clear, b_cmp, b_score, b_won, b_lost;
  logic [1:0] b_pos, b_idx;
  logic [1:0] b_gc;

  logic       o_code, o_guess, o_clear, o_cmp, o_score, o_won, o_lost;
  logic [1:0] o_pos, o_idx;
  logic [3:0] o_gc;

  ev_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  mastermind_round_ctrl #(.MAX_GUESSES(8), .CNT_W(4)) dut_a (
    .clk(clk), .resetn(resetn_a), .load(load), .red_in(red_in),
    .load_code_en(a_code), .load_guess_en(a_guess), .pos_sel(a_pos),
    .cmp_clear(a_clear), .cmp_en(a_cmp), .cmp_idx(a_idx), .score_valid(a_score),
    .guess_count(a_gc), .game_won(a_won), .game_lost(a_lost)
  );

  mastermind_round_ctrl #(.MAX_GUESSES(2), .CNT_W(2)) dut_b (
    .clk(clk), .resetn(resetn_b), .load(load), .red_in(red_in),
    .load_code_en(b_code), .load_guess_en(b_guess), .pos_sel(b_pos),
    .cmp_clear(b_clear), .cmp_en(b_cmp), .cmp_idx(b_idx), .score_valid(b_score),
    .guess_count(b_gc), .game_won(b_won), .game_lost(b_lost)
  );

  assign o_code  = use_b ? b_code  : a_code;
  assign o_guess = use_b ? b_guess : a_guess;
  assign o_pos   = use_b ? b_pos   : a_pos;
  assign o_clear = use_b ? b_clear : a_clear;
  assign o_cmp   = use_b ? b_cmp   : a_cmp;
  assign o_idx   = use_b ? b_idx   : a_idx;
  assign o_score = use_b ? b_score : a_score;
  assign o_gc    = use_b ? {2'b00, b_gc} : a_gc;
  assign o_won   = use_b ? b_won   : a_won;
  assign o_lost  = use_b ? b_lost  : a_lost;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [1:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic match_ev(input ev_kind_t k, input logic [1:0] v);
    ev_t e;
    check("event_expected", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      check("event_val", 32'(v), 32'(e.val));
    end
  endtask

  // Monitor: every strobe seen mid-cycle must match the head of the expectation queue.
  always @(negedge clk) begin
    if (o_code)  match_ev(K_CODE, o_pos);
    if (o_guess) match_ev(K_GUESS, o_pos);
    if (o_clear) match_ev(K_CLEAR, 2'd0);
    if (o_cmp)   match_ev(K_CMP, o_idx);
    if (o_score) match_ev(K_SCORE, 2'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int hold);
    load = 1'b1;
    repeat (hold) tick();
    load = 1'b0;
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_code_en"},  32'(o_code),  32'd0);
    check({tag, "_guess_en"}, 32'(o_guess), 32'd0);
    check({tag, "_pos_sel"},  32'(o_pos),   32'd0);
    check({tag, "_clear"},    32'(o_clear), 32'd0);
    check({tag, "_cmp_en"},   32'(o_cmp),   32'd0);
    check({tag, "_cmp_idx"},  32'(o_idx),   32'd0);
    check({tag, "_score"},    32'(o_score), 32'd0);
    check({tag, "_gcount"},   32'(o_gc),    32'd0);
    check({tag, "_won"},      32'(o_won),   32'd0);
    check({tag, "_lost"},     32'(o_lost),  32'd0);
  endtask

  task automatic do_reset();
    resetn_a = 1'b0;
    resetn_b = 1'b0;
    exp_q.delete();
    tick();
    tick();
    check_zero("reset");
    if (use_b) resetn_b = 1'b1;
    else       resetn_a = 1'b1;
    tick();
  endtask

  task automatic queue_drained(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic code_entry(input int hold);
    for (int i = 0; i < 4; i++) begin
      expect_ev(K_CODE, 2'(i));
      press(hold);
    end
    queue_drained("code_entry_drained");
  endtask

  task automatic guess(input logic [2:0] red, input int hold);
    red_in = red;
    for (int i = 0; i < 4; i++) begin
      expect_ev(K_GUESS, 2'(i));
      if (i == 3) begin
        expect_ev(K_CLEAR, 2'd0);
        for (int j = 0; j < 4; j++) expect_ev(K_CMP, 2'(j));
        expect_ev(K_SCORE, 2'd0);
      end
      press(hold);
    end
    repeat (8) tick();
    queue_drained("guess_drained");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    use_b    = 1'b0;
    resetn_a = 1'b0;
    resetn_b = 1'b0;
    red_in   = 3'd0;

    // 1: load held through reset release is not a press
    load = 1'b1;
    do_reset();
    repeat (10) tick();
    queue_drained("held_load_no_strobe");
    load = 1'b0;
    tick();
    expect_ev(K_CODE, 2'd0);
    press(1);
    queue_drained("first_press_strobe");

    // 2: four long presses load code positions 0..3
    load = 1'b0;
    do_reset();
    code_entry(5);

    // 3: guess with red=2, measure press-to-score latency
    red_in = 3'd2;
    for (int i = 0; i < 3; i++) begin
      expect_ev(K_GUESS, 2'(i));
      press(5);
    end
    expect_ev(K_GUESS, 2'd3);
    expect_ev(K_CLEAR, 2'd0);
    for (int j = 0; j < 4; j++) expect_ev(K_CMP, 2'(j));
    expect_ev(K_SCORE, 2'd0);
    load = 1'b1;
    n = 0;
    while (!o_score && n < 20) begin
      tick();
      n++;
    end
    check("score_latency", 32'(n), 32'd6);
    load = 1'b0;
    repeat (4) tick();
    queue_drained("guess1_drained");
    check("g1_count", 32'(o_gc), 32'd1);
    check("g1_won", 32'(o_won), 32'd0);
    check("g1_lost", 32'(o_lost), 32'd0);

    // 4: winning guess, then a press restarts the game without a strobe
    guess(3'd4, 2);
    check("win_won", 32'(o_won), 32'd1);
    check("win_lost", 32'(o_lost), 32'd0);
    check("win_count", 32'(o_gc), 32'd2);
    press(3);
    queue_drained("restart_no_strobe");
    check("restart_won", 32'(o_won), 32'd0);
    check("restart_count", 32'(o_gc), 32'd0);
    code_entry(1);
    guess(3'd4, 1);
    check("win1_won", 32'(o_won), 32'd1);
    check("win1_count", 32'(o_gc), 32'd1);
    press(1);
    check("win1_exit_won", 32'(o_won), 32'd0);

    // loss after 8 guesses; red>4 must not count as a win
    code_entry(1);
    for (int g = 0; g < 8; g++) begin
      guess(3'd5, 1);
      check("loss_count", 32'(o_gc), 32'(g + 1));
      check("loss_lost", 32'(o_lost), 32'(g == 7));
      check("loss_won", 32'(o_won), 32'd0);
    end
    press(2);
    queue_drained("loss_exit_no_strobe");
    check("loss_exit_lost", 32'(o_lost), 32'd0);
    check("loss_exit_count", 32'(o_gc), 32'd0);

    // 5: MAX_GUESSES=2 instance
    use_b = 1'b1;
    do_reset();
    code_entry(1);
    guess(3'd1, 1);
    check("m2_g1_lost", 32'(o_lost), 32'd0);
    check("m2_g1_count", 32'(o_gc), 32'd1);
    guess(3'd1, 1);
    check("m2_g2_lost", 32'(o_lost), 32'd1);
    check("m2_g2_won", 32'(o_won), 32'd0);
    check("m2_g2_count", 32'(o_gc), 32'd2);
    press(1);
    check("m2_exit_lost", 32'(o_lost), 32'd0);
    check("m2_exit_count", 32'(o_gc), 32'd0);
    code_entry(1);
    guess(3'd1, 1);
    guess(3'd4, 1);
    check("m2_final_won", 32'(o_won), 32'd1);
    check("m2_final_lost", 32'(o_lost), 32'd0);
    check("m2_final_count", 32'(o_gc), 32'd2);

    // 6: async reset on the 2nd compare cycle, with a press ignored during CMP
    use_b = 1'b0;
    do_reset();
    code_entry(1);
    red_in = 3'd0;
    for (int i = 0; i < 3; i++) begin
      expect_ev(K_GUESS, 2'(i));
      press(1);
    end
    expect_ev(K_GUESS, 2'd3);
    expect_ev(K_CLEAR, 2'd0);
    expect_ev(K_CMP, 2'd0);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1;
    tick();
    check("mid_cmp_en", 32'(o_cmp), 32'd1);
    check("mid_cmp_idx", 32'(o_idx), 32'd1);
    #1 resetn_a = 1'b0;
    #1 check_zero("async");
    tick();
    tick();
    queue_drained("abort_drained");
    resetn_a = 1'b1;
    repeat (3) tick();
    load = 1'b0;
    tick();
    queue_drained("post_reset_quiet");
    code_entry(1);
    guess(3'd2, 1);
    check("post_abort_count", 32'(o_gc), 32'd1);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
